alu_sequencer: RTL



---
 rtl/alu_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle controller in front of the 16-bit ALU: builds SUB and variable SHL out of
// repeated single ALU passes and owns the architectural Z/N/C/V flag register.
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [3:0]       cmd_cnt,
    output logic [3:0]       alu_func_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_shift,
    output logic             alu_z,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_NOTA = 4'd5;
    localparam logic [3:0] OP_NOTB = 4'd6;
    localparam logic [3:0] OP_INCA = 4'd7;
    localparam logic [3:0] OP_INCB = 4'd8;
    localparam logic [3:0] OP_DECB = 4'd9;
    localparam logic [3:0] OP_CLR  = 4'd10;
    localparam logic [3:0] OP_CLC  = 4'd11;
    localparam logic [3:0] OP_CLZ  = 4'd12;
    localparam logic [3:0] OP_SZ   = 4'd13;

    localparam logic [3:0] F_ADD  = 4'd1;
    localparam logic [3:0] F_AND  = 4'd2;
    localparam logic [3:0] F_CLR  = 4'd3;
    localparam logic [3:0] F_NOTB = 4'd5;
    localparam logic [3:0] F_INCB = 4'd6;
    localparam logic [3:0] F_DECB = 4'd7;
    localparam logic [3:0] F_INCA = 4'd10;
    localparam logic [3:0] F_NOTA = 4'd14;
    localparam logic [3:0] F_LSH  = 4'd15;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       pass_q, pass_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_v_q, flag_v_d;
    logic             accept_s;
    logic             last_pass_s;

    assign accept_s  = cmd_valid & cmd_ready;
    assign cmd_ready = (state_q == ST_IDLE) & ~rst;
    assign busy      = (state_q == ST_EXEC);
    assign alu_shift = 3'd0;
    assign alu_z     = flag_z_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;

    // ALU drive for the current pass; SUB is NOTB, INCB, then ADD on the negated B
    always_comb begin
        alu_func_sel = 4'd0;
        alu_a        = '0;
        alu_b        = '0;
        last_pass_s  = 1'b0;
        if (state_q == ST_EXEC) begin
            alu_a       = a_q;
            alu_b       = b_q;
            last_pass_s = 1'b1;
            case (op_q)
                OP_ADD:  alu_func_sel = F_ADD;
                OP_AND:  alu_func_sel = F_AND;
                OP_NOTA: alu_func_sel = F_NOTA;
                OP_NOTB: alu_func_sel = F_NOTB;
                OP_INCA: alu_func_sel = F_INCA;
                OP_INCB: alu_func_sel = F_INCB;
                OP_DECB: alu_func_sel = F_DECB;
                OP_CLR:  alu_func_sel = F_CLR;
                OP_SUB: begin
                    case (pass_q)
                        4'd0:    alu_func_sel = F_NOTB;
                        4'd1:    alu_func_sel = F_INCB;
                        default: alu_func_sel = F_ADD;
                    endcase
                    last_pass_s = (pass_q == 4'd2);
                end
                OP_SHL: begin
                    alu_func_sel = F_LSH;
                    last_pass_s  = (pass_q == (cnt_q - 4'd1));
                end
                default: alu_func_sel = 4'd0;
            endcase
        end else begin
            last_pass_s = 1'b0;
        end
    end

    // Next-state, operand write-back, result and flag update
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        pass_d      = pass_q;
        res_data_d  = res_data_q;
        res_valid_d = 1'b0;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        flag_c_d    = flag_c_q;
        flag_v_d    = flag_v_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d   = cmd_op;
                    a_d    = cmd_a;
                    b_d    = cmd_b;
                    cnt_d  = cmd_cnt;
                    pass_d = 4'd0;
                    case (cmd_op)
                        OP_ADD, OP_AND, OP_SUB, OP_NOTA, OP_NOTB,
                        OP_INCA, OP_INCB, OP_DECB, OP_CLR: state_d = ST_EXEC;
                        OP_SHL: begin
                            if (cmd_cnt != 4'd0) begin
                                state_d = ST_EXEC;
                            end else begin
                                res_data_d  = cmd_a;
                                res_valid_d = 1'b1;
                                flag_z_d    = ~|cmd_a;
                                flag_n_d    = cmd_a[WIDTH-1];
                                flag_c_d    = 1'b0;
                                flag_v_d    = 1'b0;
                            end
                        end
                        OP_CLC:  flag_c_d = 1'b0;
                        OP_CLZ:  flag_z_d = 1'b0;
                        OP_SZ:   flag_z_d = 1'b1;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                pass_d = pass_q + 4'd1;
                if ((op_q == OP_SUB) && !last_pass_s) begin
                    b_d = alu_f;
                end else begin
                    b_d = b_q;
                end
                if (op_q == OP_SHL) begin
                    a_d = alu_f;
                end else begin
                    a_d = a_q;
                end
                // Intermediate-pass carry/overflow are dropped; only the final pass lands in the flags
                if (last_pass_s) begin
                    state_d     = ST_IDLE;
                    res_data_d  = alu_f;
                    res_valid_d = 1'b1;
                    flag_z_d    = ~|alu_f;
                    flag_n_d    = alu_f[WIDTH-1];
                    flag_c_d    = alu_carry;
                    flag_v_d    = alu_overflow;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 4'd0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= 4'd0;
            pass_q      <= 4'd0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            pass_q      <= pass_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            flag_c_q    <= flag_c_d;
            flag_v_q    <= flag_v_d;
        end
    end

endmodule
